// File: rtl/lru_replacement_unit.sv
// True-LRU victim selector: per-set way ages (0 = MRU, WAY-1 = LRU) updated on hit/fill
// reports, and a sequential scan that returns the oldest way of a full set on request.
module lru_replacement_unit #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int SET             = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    parameter int SET_INDEX       = $clog2(SET),
    parameter int AGE_W           = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_INDEX-1:0] index,
    input  logic                 access_valid,
    input  logic [4:0]           access_way,
    input  logic                 replace_req,
    output logic [4:0]           replace_way,
    output logic                 block_replace,
    output logic                 busy
);

    // Handshake: replace_req is a level held by the update stage until it sees the
    // one-cycle block_replace pulse; replace_way is meaningful only during that pulse.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT_DROP
    } state_t;

    localparam logic [4:0]           WAY_LIM  = 5'(WAY);
    localparam logic [AGE_W-1:0]     LAST_WAY = AGE_W'(WAY - 1);
    localparam logic [SET_INDEX-1:0] LAST_SET = SET_INDEX'(SET - 1);

    logic [AGE_W-1:0] age_mem [SET][WAY];

    state_t               state_q, state_d;
    logic [SET_INDEX-1:0] init_set_q, init_set_d;
    logic [SET_INDEX-1:0] idx_q, idx_d;
    logic [AGE_W-1:0]     scan_way_q, scan_way_d;
    logic [AGE_W-1:0]     best_age_q, best_age_d;
    logic [AGE_W-1:0]     best_way_q, best_way_d;

    logic                 access_ok;
    logic [AGE_W-1:0]     acc_way;
    logic [AGE_W-1:0]     scan_age;
    logic                 init_en;
    logic                 upd_en;
    logic [SET_INDEX-1:0] upd_set;
    logic [AGE_W-1:0]     upd_way;
    logic [AGE_W-1:0]     upd_age;
    logic                 issue;

    assign access_ok = access_valid && (access_way < WAY_LIM);
    assign acc_way   = access_way[AGE_W-1:0];
    assign scan_age  = age_mem[idx_q][scan_way_q];
    assign upd_age   = age_mem[upd_set][upd_way];

    assign busy = (state_q == ST_INIT) || (state_q == ST_SCAN) || (state_q == ST_ISSUE);

    always_comb begin
        state_d    = state_q;
        init_set_d = init_set_q;
        idx_d      = idx_q;
        scan_way_d = scan_way_q;
        best_age_d = best_age_q;
        best_way_d = best_way_q;
        init_en    = 1'b0;
        upd_en     = 1'b0;
        upd_set    = index;
        upd_way    = acc_way;
        issue      = 1'b0;

        case (state_q)
            ST_INIT: begin
                init_en    = 1'b1;
                init_set_d = init_set_q + 1'b1;
                if (init_set_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (access_valid) begin
                    upd_en = access_ok;
                end else if (replace_req) begin
                    idx_d      = index;
                    scan_way_d = '0;
                    best_age_d = '0;
                    best_way_d = '0;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Strict greater-than keeps the lower way on a tie.
                if (scan_age > best_age_q) begin
                    best_age_d = scan_age;
                    best_way_d = scan_way_q;
                end
                if (scan_way_q == LAST_WAY) begin
                    state_d = ST_ISSUE;
                end else begin
                    scan_way_d = scan_way_q + 1'b1;
                end
                if (access_ok) begin
                    upd_en = 1'b1;
                    // The scanned set just changed under us: partial result is stale.
                    if (index == idx_q) begin
                        scan_way_d = '0;
                        best_age_d = '0;
                        best_way_d = '0;
                        state_d    = ST_SCAN;
                    end
                end
            end

            ST_ISSUE: begin
                // The victim's own MRU update owns the write port this cycle.
                issue   = 1'b1;
                upd_en  = 1'b1;
                upd_set = idx_q;
                upd_way = best_way_q;
                state_d = ST_WAIT_DROP;
            end

            ST_WAIT_DROP: begin
                upd_en = access_ok;
                if (!replace_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_set_q    <= '0;
            idx_q         <= '0;
            scan_way_q    <= '0;
            best_age_q    <= '0;
            best_way_q    <= '0;
            block_replace <= 1'b0;
            replace_way   <= '0;
        end else begin
            state_q       <= state_d;
            init_set_q    <= init_set_d;
            idx_q         <= idx_d;
            scan_way_q    <= scan_way_d;
            best_age_q    <= best_age_d;
            best_way_q    <= best_way_d;
            block_replace <= issue;
            if (issue) begin
                replace_way <= 5'(best_way_q);
            end
        end
    end

    // Age storage has no reset of its own; INIT rebuilds the identity ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_en) begin
                for (int w = 0; w < WAY; w++) begin
                    age_mem[init_set_q][w] <= AGE_W'(w);
                end
            end else if (upd_en) begin
                for (int w = 0; w < WAY; w++) begin
                    if (AGE_W'(w) == upd_way) begin
                        age_mem[upd_set][w] <= '0;
                    end else if (age_mem[upd_set][w] < upd_age) begin
                        age_mem[upd_set][w] <= age_mem[upd_set][w] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lru_replacement_unit.sv
// Bench for lru_replacement_unit: reference age model, expected-victim queue checked by a
// pulse monitor, and one task per scenario.
module tb_lru_replacement_unit;

    localparam int WAY = 4;
    localparam int SET = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] index;
    logic       access_valid;
    logic [4:0] access_way;
    logic       replace_req;
    logic [4:0] replace_way;
    logic       block_replace;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;
    int model_age[SET][WAY];

    lru_replacement_unit dut (
        .clk          (clk),
        .rst          (rst),
        .index        (index),
        .access_valid (access_valid),
        .access_way   (access_way),
        .replace_req  (replace_req),
        .replace_way  (replace_way),
        .block_replace(block_replace),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_init();
        for (int s = 0; s < SET; s++)
            for (int w = 0; w < WAY; w++)
                model_age[s][w] = w;
    endfunction

    function automatic void model_access(input int s, input int w);
        int a;
        if (w >= WAY) return;
        a = model_age[s][w];
        for (int v = 0; v < WAY; v++)
            if (model_age[s][v] < a) model_age[s][v] = model_age[s][v] + 1;
        model_age[s][w] = 0;
    endfunction

    function automatic int model_lru(input int s);
        int best;
        best = 0;
        for (int v = 1; v < WAY; v++)
            if (model_age[s][v] > model_age[s][best]) best = v;
        return best;
    endfunction

    // Every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (block_replace === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: block_replace=1 replace_way=%0d, required no pulse", replace_way);
            end else begin
                mon_exp = exp_q.pop_front();
                if (replace_way !== mon_exp) begin
                    errors++;
                    $display("FAIL replace_way: got %0d, required %0d", replace_way, mon_exp);
                end
            end
        end
    end

    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (block_replace === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_access(input int s, input int w);
        index        = 9'(s);
        access_way   = 5'(w);
        access_valid = 1'b1;
        model_access(s, w);
        @(negedge clk);
        access_valid = 1'b0;
    endtask

    // Issues one replace request on set s and checks latency and single pulse.
    task automatic run_replace(input int s, input int exp_lat, input string name);
        int lat;
        int v;
        v = model_lru(s);
        exp_q.push_back(5'(v));
        model_access(s, v);
        index       = 9'(s);
        replace_req = 1'b1;
        wait_pulse(lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        replace_req = 1'b0;
        @(negedge clk);
        checks++;
        if (block_replace !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: block_replace=%b, required 0", name, block_replace);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        rst          = 1'b1;
        index        = '0;
        access_valid = 1'b0;
        access_way   = '0;
        replace_req  = 1'b0;
        model_init();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (block_replace !== 1'b0 || replace_way !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: block_replace=%b replace_way=%0d, required 0/0", block_replace, replace_way);
        end
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            // Accesses during INIT must be dropped.
            access_valid = (i == 100);
            index        = 9'd5;
            access_way   = 5'd3;
            @(negedge clk);
        end
        access_valid = 1'b0;
        checks++;
        if (cnt != SET) begin
            errors++;
            $display("FAIL init_busy_cycles: got %0d, required %0d", cnt, SET);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
        run_replace(5, WAY + 2, "init_set5");
    endtask

    task automatic test_lru_order();
        do_access(7, 3);
        do_access(7, 2);
        do_access(7, 1);
        run_replace(7, WAY + 2, "set7_first");
        run_replace(7, WAY + 2, "set7_after_mru");
        for (int i = 0; i < 4; i++) begin
            int s;
            s = $urandom_range(100, 200);
            do_access(s, $urandom_range(0, WAY - 1));
            do_access(s, $urandom_range(0, WAY - 1));
            run_replace(s, WAY + 2, "random_set");
        end
        do_access(20, $urandom_range(WAY, 31));
        run_replace(20, WAY + 2, "invalid_way_ignored");
    endtask

    task automatic test_back_to_back();
        run_replace(4, WAY + 2, "b2b_first");
        run_replace(4, WAY + 2, "b2b_second");
    endtask

    task automatic test_same_cycle();
        int lat;
        int v;
        model_access(9, 3);
        v = model_lru(9);
        exp_q.push_back(5'(v));
        model_access(9, v);
        index        = 9'd9;
        access_way   = 5'd3;
        access_valid = 1'b1;
        replace_req  = 1'b1;
        @(negedge clk);
        access_valid = 1'b0;
        wait_pulse(lat);
        checks++;
        if (lat < 0 || lat + 1 != WAY + 3) begin
            errors++;
            $display("FAIL same_cycle_latency: got %0d, required %0d", (lat < 0) ? lat : lat + 1, WAY + 3);
        end
        replace_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_scan_restart();
        int lat;
        int v;
        model_access(11, 1);
        v = model_lru(11);
        exp_q.push_back(5'(v));
        model_access(11, v);
        index       = 9'd11;
        replace_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        access_way   = 5'd1;
        access_valid = 1'b1;
        @(negedge clk);
        access_valid = 1'b0;
        wait_pulse(lat);
        checks++;
        if (lat < 0 || lat + 3 != WAY + 4) begin
            errors++;
            $display("FAIL restart_latency: got %0d, required %0d", (lat < 0) ? lat : lat + 3, WAY + 4);
        end
        replace_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // An access to a different set must not disturb the running scan.
        v = model_lru(12);
        exp_q.push_back(5'(v));
        model_access(12, v);
        index       = 9'd12;
        replace_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        index        = 9'd30;
        access_way   = 5'd2;
        access_valid = 1'b1;
        model_access(30, 2);
        @(negedge clk);
        access_valid = 1'b0;
        wait_pulse(lat);
        checks++;
        if (lat < 0 || lat + 3 != WAY + 2) begin
            errors++;
            $display("FAIL other_set_latency: got %0d, required %0d", (lat < 0) ? lat : lat + 3, WAY + 2);
        end
        replace_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run_replace(30, WAY + 2, "other_set_applied");
    endtask

    task automatic test_reset_mid_scan();
        int cnt;
        index       = 9'd13;
        replace_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b1;
        replace_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_init();
        checks++;
        if (block_replace !== 1'b0 || replace_way !== 5'd0) begin
            errors++;
            $display("FAIL midscan_reset_outputs: block_replace=%b replace_way=%0d, required 0/0", block_replace, replace_way);
        end
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != SET) begin
            errors++;
            $display("FAIL midscan_init_busy: got %0d, required %0d", cnt, SET);
        end
        run_replace(13, WAY + 2, "reinit_set13");
        run_replace(7, WAY + 2, "reinit_set7");
        run_replace(4, WAY + 2, "reinit_set4");
        run_replace($urandom_range(0, SET - 1), WAY + 2, "reinit_random");
    endtask

    initial begin
        test_reset();
        test_lru_order();
        test_back_to_back();
        test_same_cycle();
        test_scan_restart();
        test_reset_mid_scan();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
